// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock/strobe divider running from clk50Mhz.
// Each channel produces a square wave or a one-cycle strobe, with glitch-free divisor updates.
module prog_clock_divider #(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 2
) (
    input  logic                    clk50Mhz,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       mode,
    input  logic [NUM_CH*WIDTH-1:0] divider,
    input  logic [NUM_CH-1:0]       sync,
    output logic [NUM_CH-1:0]       slow_clk,
    output logic [NUM_CH-1:0]       tick
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] div_act;
        logic             mode_act;
        logic             slow_q;
        logic             tick_q;
        logic [WIDTH-1:0] div_in;
        logic [WIDTH-1:0] term_cnt;

        assign div_in = divider[i*WIDTH +: WIDTH];
        // A zero divisor behaves as divide-by-one, so the terminal count is 0.
        assign term_cnt = (div_act == '0) ? '0 : div_act - WIDTH'(1);

        always_ff @(posedge clk50Mhz or negedge rst_n) begin
            if (!rst_n) begin
                cnt      <= '0;
                div_act  <= '0;
                mode_act <= 1'b0;
                slow_q   <= 1'b0;
                tick_q   <= 1'b0;
            end else if (!en[i] || sync[i]) begin
                cnt      <= '0;
                slow_q   <= 1'b0;
                tick_q   <= 1'b0;
                div_act  <= div_in;
                mode_act <= mode[i];
            end else if (cnt == term_cnt) begin
                // Divisor and mode are only picked up here, so a period always completes.
                cnt      <= '0;
                tick_q   <= 1'b1;
                slow_q   <= mode_act ? 1'b1 : ~slow_q;
                div_act  <= div_in;
                mode_act <= mode[i];
            end else begin
                cnt    <= cnt + WIDTH'(1);
                tick_q <= 1'b0;
                if (mode_act) begin
                    slow_q <= 1'b0;
                end
            end
        end

        assign slow_clk[i] = slow_q;
        assign tick[i]     = tick_q;
    end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed bench for prog_clock_divider: vector table for the steady-state waveforms,
// plus hand-written sequences for updates, sync, enable gaps, max divisor and async reset.
module tb_prog_clock_divider;

    localparam int W = 8;

    logic         clk50Mhz = 1'b0;
    logic         rst_n;
    logic [1:0]   en;
    logic [1:0]   mode;
    logic [15:0]  divider;
    logic [1:0]   sync;
    logic [1:0]   slow_clk;
    logic [1:0]   tick;

    int checks = 0;
    int errors = 0;

    prog_clock_divider #(.WIDTH(W), .NUM_CH(2)) dut (
        .clk50Mhz (clk50Mhz),
        .rst_n    (rst_n),
        .en       (en),
        .mode     (mode),
        .divider  (divider),
        .sync     (sync),
        .slow_clk (slow_clk),
        .tick     (tick)
    );

    always #5 clk50Mhz = ~clk50Mhz;

    typedef struct {
        logic [1:0] en;
        logic [1:0] mode;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] sync;
        logic [1:0] exp_slow;
        logic [1:0] exp_tick;
    } vec_t;

    vec_t vecs [17];

    task automatic step();
        @(posedge clk50Mhz);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_div(input logic [7:0] d0, input logic [7:0] d1);
        divider = {d1, d0};
    endtask

    initial begin
        logic [15:0] pat_s0;
        logic [15:0] pat_t0;
        logic [15:0] pat_1;
        logic [7:0]  exp_t1_zero;
        logic [10:0] exp_t0_upd;
        logic [3:0]  exp_sync;

        // Hand-derived waveforms, leftmost bit = counting edge 1.
        pat_s0      = 16'b0001111000011110;  // ch0 toggle D=4
        pat_t0      = 16'b0001000100010001;
        pat_1       = 16'b0000100001000010;  // ch1 pulse D=5 (tick == slow_clk)
        exp_t1_zero = 8'b00011111;           // edges 17..24 after divider1 -> 0
        exp_t0_upd  = 11'b00000101010;       // D=6 then 2: terminals at 6, 8, 10
        exp_sync    = 4'b0001;

        vecs[0] = '{en: 2'b00, mode: 2'b10, d0: 8'd4, d1: 8'd5, sync: 2'b00,
                    exp_slow: 2'b00, exp_tick: 2'b00};
        for (int k = 1; k <= 16; k++) begin
            vecs[k] = '{en: 2'b11, mode: 2'b10, d0: 8'd4, d1: 8'd5, sync: 2'b00,
                        exp_slow: {pat_1[16-k], pat_s0[16-k]},
                        exp_tick: {pat_1[16-k], pat_t0[16-k]}};
        end

        // Reset held with channels enabled.
        rst_n = 1'b0;
        en    = 2'b11;
        mode  = 2'b00;
        sync  = 2'b00;
        set_div(8'd3, 8'd3);
        repeat (3) step();
        chk("reset_slow_clk", 32'(slow_clk), 32'd0);
        chk("reset_tick", 32'(tick), 32'd0);
        en    = 2'b00;
        rst_n = 1'b1;

        // Table: ch0 toggle D=4 and ch1 pulse D=5 together.
        for (int k = 0; k < 17; k++) begin
            en   = vecs[k].en;
            mode = vecs[k].mode;
            sync = vecs[k].sync;
            set_div(vecs[k].d0, vecs[k].d1);
            step();
            chk($sformatf("tbl_slow[%0d]", k), 32'(slow_clk), 32'(vecs[k].exp_slow));
            chk($sformatf("tbl_tick[%0d]", k), 32'(tick), 32'(vecs[k].exp_tick));
        end

        // ch1 divisor -> 0 mid-period: old period finishes, then tick stays high.
        set_div(8'd4, 8'd0);
        for (int k = 17; k <= 24; k++) begin
            step();
            chk($sformatf("zero_div_tick1[%0d]", k), 32'(tick[1]), 32'(exp_t1_zero[24-k]));
            chk($sformatf("zero_div_slow1[%0d]", k), 32'(slow_clk[1]), 32'(exp_t1_zero[24-k]));
        end

        // ch0 divisor 6 changed to 2 during the first period.
        en = 2'b10;
        set_div(8'd6, 8'd0);
        step();
        chk("upd_idle_tick0", 32'(tick[0]), 32'd0);
        en = 2'b11;
        for (int k = 1; k <= 11; k++) begin
            step();
            chk($sformatf("upd_tick0[%0d]", k), 32'(tick[0]), 32'(exp_t0_upd[11-k]));
            if (k == 2) set_div(8'd2, 8'd0);
        end

        // Sync on ch0 while its square wave is high; ch1 (D=1 pulse) keeps ticking.
        mode = 2'b10;
        en   = 2'b10;
        set_div(8'd4, 8'd0);
        step();
        en = 2'b11;
        repeat (5) step();
        chk("sync_pre_slow0", 32'(slow_clk[0]), 32'd1);
        sync = 2'b01;
        step();
        chk("sync_slow0", 32'(slow_clk[0]), 32'd0);
        chk("sync_tick0", 32'(tick[0]), 32'd0);
        chk("sync_tick1", 32'(tick[1]), 32'd1);
        sync = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("post_sync_tick0[%0d]", k), 32'(tick[0]), 32'(exp_sync[4-k]));
            chk($sformatf("post_sync_slow0[%0d]", k), 32'(slow_clk[0]), 32'(exp_sync[4-k]));
            chk($sformatf("post_sync_tick1[%0d]", k), 32'(tick[1]), 32'd1);
        end

        // Independence: ch0 D=3 toggle gated on/off, ch1 D=7 pulse unaffected.
        mode = 2'b10;
        en   = 2'b00;
        set_div(8'd3, 8'd7);
        step();
        for (int k = 1; k <= 42; k++) begin
            en = {1'b1, ((k / 5) % 2 == 0)};
            step();
            chk($sformatf("indep_tick1[%0d]", k), 32'(tick[1]), 32'(k % 7 == 0));
            if (!en[0]) begin
                chk($sformatf("indep_off_ch0[%0d]", k), 32'({slow_clk[0], tick[0]}), 32'd0);
            end
        end

        // Maximum divisor 255 on ch0.
        mode = 2'b00;
        en   = 2'b00;
        set_div(8'd255, 8'd7);
        step();
        en = 2'b01;
        for (int k = 1; k <= 256; k++) begin
            step();
            if (k == 254) begin
                chk("max_tick0_254", 32'(tick[0]), 32'd0);
                chk("max_slow0_254", 32'(slow_clk[0]), 32'd0);
            end
            if (k == 255) begin
                chk("max_tick0_255", 32'(tick[0]), 32'd1);
                chk("max_slow0_255", 32'(slow_clk[0]), 32'd1);
            end
            if (k == 256) begin
                chk("max_tick0_256", 32'(tick[0]), 32'd0);
                chk("max_slow0_256", 32'(slow_clk[0]), 32'd1);
            end
        end

        // Asynchronous reset between clock edges while outputs are high.
        mode = 2'b10;
        en   = 2'b00;
        set_div(8'd4, 8'd1);
        step();
        en = 2'b11;
        repeat (5) step();
        chk("pre_arst_slow0", 32'(slow_clk[0]), 32'd1);
        chk("pre_arst_tick1", 32'(tick[1]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_slow_clk", 32'(slow_clk), 32'd0);
        chk("arst_tick", 32'(tick), 32'd0);
        step();
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
